// File: rtl/commit_reg_release_pkg.sv
// Shared sizing for the commit-side register release path.
// The free list and rename map table import the same values.
package commit_reg_release_pkg;

    localparam int SIZE_LOGICAL      = 32;
    localparam int SIZE_LOGICAL_LOG  = 5;
    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int RETIRE_WIDTH      = 4;

endpackage

// File: rtl/commit_reg_release_amt.sv
// Architectural Map Table: flop-array storage with 4 combinational reads and 4 writes.
// On an address collision, the highest-numbered write port wins.
module arch_map_table_4r4w
    import commit_reg_release_pkg::*;
#(
    parameter int NUM_LOG  = SIZE_LOGICAL,
    parameter int LOG_W    = SIZE_LOGICAL_LOG,
    parameter int PHYS_W   = SIZE_PHYSICAL_LOG
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [RETIRE_WIDTH-1:0][LOG_W-1:0]   rd_addr,
    output logic [RETIRE_WIDTH-1:0][PHYS_W-1:0]  rd_data,
    input  logic [RETIRE_WIDTH-1:0]              wr_en,
    input  logic [RETIRE_WIDTH-1:0][LOG_W-1:0]   wr_addr,
    input  logic [RETIRE_WIDTH-1:0][PHYS_W-1:0]  wr_data
);

    logic [PHYS_W-1:0] map [NUM_LOG];

    always_comb begin
        for (int p = 0; p < RETIRE_WIDTH; p++) begin
            rd_data[p] = map[rd_addr[p]];
        end
    end

    // NOTE: this array is reset on purpose: identity mapping is architectural state,
    // so every entry needs a defined value out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOG; i++) begin
                map[i] <= PHYS_W'(i);
            end
        end else begin
            // Ascending port order makes the last (highest) port's write land.
            for (int p = 0; p < RETIRE_WIDTH; p++) begin
                if (wr_en[p]) begin
                    map[wr_addr[p]] <= wr_data[p];
                end
            end
        end
    end

endmodule

// File: rtl/commit_reg_release.sv
// Commit-side producer for the free list: looks up each retiring destination's
// previous mapping, updates the AMT and releases the old register one cycle later.
module commit_reg_release
    import commit_reg_release_pkg::*;
#(
    parameter int SIZE_LOGICAL      = commit_reg_release_pkg::SIZE_LOGICAL,
    parameter int SIZE_LOGICAL_LOG  = commit_reg_release_pkg::SIZE_LOGICAL_LOG,
    parameter int SIZE_PHYSICAL_LOG = commit_reg_release_pkg::SIZE_PHYSICAL_LOG
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         retireValid0_i,
    input  logic                         retireValid1_i,
    input  logic                         retireValid2_i,
    input  logic                         retireValid3_i,
    input  logic [SIZE_LOGICAL_LOG-1:0]  retireLogDest0_i,
    input  logic [SIZE_LOGICAL_LOG-1:0]  retireLogDest1_i,
    input  logic [SIZE_LOGICAL_LOG-1:0]  retireLogDest2_i,
    input  logic [SIZE_LOGICAL_LOG-1:0]  retireLogDest3_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] retirePhyDest0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] retirePhyDest1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] retirePhyDest2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] retirePhyDest3_i,
    output logic                         commitValid0_o,
    output logic                         commitValid1_o,
    output logic                         commitValid2_o,
    output logic                         commitValid3_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] commitReg0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] commitReg1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] commitReg2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] commitReg3_o
);

    logic [RETIRE_WIDTH-1:0]                         valid;
    logic [RETIRE_WIDTH-1:0][SIZE_LOGICAL_LOG-1:0]   log_dest;
    logic [RETIRE_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]  phys_dest;
    logic [RETIRE_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]  amt_rd;
    logic [RETIRE_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]  old_phys;
    logic [RETIRE_WIDTH-1:0]                         wr_en;
    logic [RETIRE_WIDTH-1:0]                         commit_valid;
    logic [RETIRE_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]  commit_reg;

    assign valid     = {retireValid3_i, retireValid2_i, retireValid1_i, retireValid0_i};
    assign log_dest  = {retireLogDest3_i, retireLogDest2_i, retireLogDest1_i, retireLogDest0_i};
    assign phys_dest = {retirePhyDest3_i, retirePhyDest2_i, retirePhyDest1_i, retirePhyDest0_i};

    arch_map_table_4r4w #(
        .NUM_LOG (SIZE_LOGICAL),
        .LOG_W   (SIZE_LOGICAL_LOG),
        .PHYS_W  (SIZE_PHYSICAL_LOG)
    ) u_amt (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (log_dest),
        .rd_data (amt_rd),
        .wr_en   (wr_en),
        .wr_addr (log_dest),
        .wr_data (phys_dest)
    );

    // Old mapping comes from the youngest older slot with the same destination,
    // else from the AMT; a slot's write is dropped if a younger slot overwrites it.
    // NOTE: defaults are assigned first so every path drives both signals and no latch is inferred.
    always_comb begin
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            old_phys[k] = amt_rd[k];
            wr_en[k]    = valid[k];
            for (int j = 0; j < RETIRE_WIDTH; j++) begin
                if (j < k && valid[j] && log_dest[j] == log_dest[k]) begin
                    old_phys[k] = phys_dest[j];
                end
                if (j > k && valid[j] && log_dest[j] == log_dest[k]) begin
                    wr_en[k] = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_valid <= '0;
            commit_reg   <= '0;
        end else begin
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                commit_valid[k] <= valid[k];
                commit_reg[k]   <= valid[k] ? old_phys[k] : '0;
            end
        end
    end

    assign commitValid0_o = commit_valid[0];
    assign commitValid1_o = commit_valid[1];
    assign commitValid2_o = commit_valid[2];
    assign commitValid3_o = commit_valid[3];
    assign commitReg0_o   = commit_reg[0];
    assign commitReg1_o   = commit_reg[1];
    assign commitReg2_o   = commit_reg[2];
    assign commitReg3_o   = commit_reg[3];

endmodule
